tick_led_sequencer: RTL and testbench

Tick-paced LED pattern sequencer that consumes the single-cycle enable pulse produced by the board's clock-divider/delay stage. It holds a small synchronous RAM of pattern entries, which is loaded through a write port. Once started, it steps through the entries and drives each pattern onto the LEDs for a programmable number of ticks. It sits directly downstream of the divider and directly upstream of the LED pins.

---
 rtl/led_seq_pkg.sv | 30 +++
 rtl/seq_ram.sv | 31 +++
 rtl/tick_led_sequencer.sv | 134 +++++++++++++
 tb/tb_tick_led_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the tick-paced LED sequencer.
package led_seq_pkg;

  localparam int ADDR_W_DFLT = 4;
  localparam int LED_W_DFLT  = 8;
  localparam int HOLD_W_DFLT = 4;

  // Entry layout: {last, hold, pattern}, pattern in the low bits.
  localparam int PAT_LSB  = 0;
  localparam int HOLD_LSB = LED_W_DFLT;
  localparam int LAST_BIT = LED_W_DFLT + HOLD_W_DFLT;
  localparam int ENTRY_W  = LED_W_DFLT + HOLD_W_DFLT + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  // Build an entry word for the default field widths.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic                   last,
    input logic [HOLD_W_DFLT-1:0] hold,
    input logic [LED_W_DFLT-1:0]  pattern
  );
    return {last, hold, pattern};
  endfunction

endpackage

// File: rtl/seq_ram.sv
// Pattern memory: synchronous write, registered read, read-before-write,
// contents untouched by reset.
module seq_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 13
) (
  input  logic              mclk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  // Write port; the array is deliberately not reset.
  always_ff @(posedge mclk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read; a same-edge write to this address is not yet visible.
  always_ff @(posedge mclk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tick_led_sequencer.sv
// Steps through RAM entries on divider ticks, holding each LED pattern for
// hold+1 ticks. stop wins over everything; tick is only honoured in SHOW.
module tick_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int LED_W  = LED_W_DFLT,
  parameter int HOLD_W = HOLD_W_DFLT
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [LED_W+HOLD_W:0]    wr_data,
  output logic [LED_W-1:0]         leds,
  output logic                     busy,
  output logic [ADDR_W-1:0]        step_addr,
  output logic                     done,
  output logic [1:0]               dbg_state
);

  localparam int EW     = LED_W + HOLD_W + 1;
  localparam int H_LSB  = LED_W;
  localparam int L_BIT  = LED_W + HOLD_W;

  state_t              r_state,  w_state_nxt;
  logic [LED_W-1:0]    r_leds,   w_leds_nxt;
  logic [HOLD_W-1:0]   r_hold,   w_hold_nxt;
  logic                r_last,   w_last_nxt;
  logic [ADDR_W-1:0]   r_addr,   w_addr_nxt;
  logic                r_done,   w_done_nxt;
  logic                w_rd_en;
  logic [EW-1:0]       w_rd_data;

  seq_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (EW)
  ) u_ram (
    .mclk      (mclk),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_addr),
    .o_rd_data (w_rd_data)
  );

  // State and datapath registers; synchronous reset clears everything but RAM.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_leds  <= '0;
      r_hold  <= '0;
      r_last  <= 1'b0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_leds  <= w_leds_nxt;
      r_hold  <= w_hold_nxt;
      r_last  <= w_last_nxt;
      r_addr  <= w_addr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and datapath decode; old pattern stays up through FETCH/LOAD.
  always_comb begin
    w_state_nxt = r_state;
    w_leds_nxt  = r_leds;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    w_addr_nxt  = r_addr;
    w_done_nxt  = 1'b0;
    w_rd_en     = 1'b0;
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_leds_nxt  = '0;
      w_hold_nxt  = '0;
      w_last_nxt  = 1'b0;
      w_addr_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
          end
        end
        S_FETCH: begin
          w_rd_en     = 1'b1;
          w_state_nxt = S_LOAD;
        end
        S_LOAD: begin
          w_leds_nxt  = w_rd_data[LED_W-1:0];
          w_hold_nxt  = w_rd_data[H_LSB +: HOLD_W];
          w_last_nxt  = w_rd_data[L_BIT];
          w_state_nxt = S_SHOW;
        end
        S_SHOW: begin
          if (tick) begin
            if (r_hold != '0) begin
              w_hold_nxt = r_hold - 1'b1;
            end else if (!r_last) begin
              w_addr_nxt  = r_addr + 1'b1;
              w_state_nxt = S_FETCH;
            end else begin
              w_done_nxt = 1'b1;
              w_addr_nxt = '0;
              if (loop_en) begin
                w_state_nxt = S_FETCH;
              end else begin
                w_state_nxt = S_IDLE;
                w_leds_nxt  = '0;
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign leds      = r_leds;
  assign busy      = (r_state != S_IDLE);
  assign step_addr = r_addr;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tick_led_sequencer.sv
// Directed bench for tick_led_sequencer: inputs change #1 after the rising
// edge and outputs are sampled at that same point.
module tb_tick_led_sequencer;
  import led_seq_pkg::*;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [12:0] wr_data = '0;
  logic [7:0]  leds;
  logic        busy;
  logic [3:0]  step_addr;
  logic        done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  tick_led_sequencer dut (
    .mclk      (mclk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .leds      (leds),
    .busy      (busy),
    .step_addr (step_addr),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 mclk = ~mclk;

  // Count done pulses away from the active edge.
  always @(negedge mclk) if (done) done_cnt++;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [12:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    checks++;
    if (leds !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || step_addr !== 4'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset leds=%h busy=%b done=%b addr=%0d st=%0d exp 00/0/0/0/0", leds, busy, done, step_addr, dbg_state);
    end
  endtask

  task automatic test_single_run();
    int d0;
    write_entry(4'd0, {1'b0, 4'd1, 8'hAA});
    write_entry(4'd1, {1'b1, 4'd0, 8'h55});
    d0 = done_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd1 || leds !== 8'h00) begin
      errors++;
      $display("FAIL run_fetch busy=%b st=%0d leds=%h exp 1/1/00", busy, dbg_state, leds);
    end
    cyc();
    checks++;
    if (dbg_state !== 2'd2 || leds !== 8'h00) begin
      errors++;
      $display("FAIL run_load st=%0d leds=%h exp 2/00", dbg_state, leds);
    end
    cyc();
    checks++;
    if (leds !== 8'hAA || step_addr !== 4'd0) begin
      errors++;
      $display("FAIL run_e0 leds=%h addr=%0d exp AA/0", leds, step_addr);
    end
    wait_cyc(4); pulse_tick();
    checks++;
    if (leds !== 8'hAA || dbg_state !== 2'd3) begin
      errors++;
      $display("FAIL run_tick1 leds=%h st=%0d exp AA/3", leds, dbg_state);
    end
    wait_cyc(4); pulse_tick();
    checks++;
    if (leds !== 8'hAA || dbg_state !== 2'd1 || step_addr !== 4'd1) begin
      errors++;
      $display("FAIL run_tick2 leds=%h st=%0d addr=%0d exp AA/1/1", leds, dbg_state, step_addr);
    end
    cyc();
    checks++;
    if (leds !== 8'hAA) begin
      errors++;
      $display("FAIL run_nogap leds=%h exp AA", leds);
    end
    cyc();
    checks++;
    if (leds !== 8'h55 || step_addr !== 4'd1) begin
      errors++;
      $display("FAIL run_e1 leds=%h addr=%0d exp 55/1", leds, step_addr);
    end
    wait_cyc(2); pulse_tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || leds !== 8'h00) begin
      errors++;
      $display("FAIL run_end done=%b busy=%b leds=%h exp 1/0/00", done, busy, leds);
    end
    wait_cyc(3);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL run_after done=%b busy=%b pulses=%0d exp 0/0/1", done, busy, done_cnt - d0);
    end
  endtask

  task automatic test_loop();
    int d0;
    loop_en = 1'b1;
    d0 = done_cnt;
    pulse_start();
    wait_cyc(2);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (leds !== 8'hAA || step_addr !== 4'd0) begin
        errors++;
        $display("FAIL loop_e0 pass=%0d leds=%h addr=%0d exp AA/0", p, leds, step_addr);
      end
      wait_cyc(4); pulse_tick();
      wait_cyc(4); pulse_tick();
      wait_cyc(2);
      checks++;
      if (leds !== 8'h55 || step_addr !== 4'd1) begin
        errors++;
        $display("FAIL loop_e1 pass=%0d leds=%h addr=%0d exp 55/1", p, leds, step_addr);
      end
      wait_cyc(2); pulse_tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || step_addr !== 4'd0 || leds !== 8'h55) begin
        errors++;
        $display("FAIL loop_wrap pass=%0d done=%b busy=%b addr=%0d leds=%h exp 1/1/0/55", p, done, busy, step_addr, leds);
      end
      wait_cyc(2);
    end
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL loop_done_cnt got=%0d exp 2", done_cnt - d0);
    end
    do_stop();
    loop_en = 1'b0;
  endtask

  task automatic test_stop();
    int d0;
    pulse_start();
    wait_cyc(2);
    pulse_tick(); pulse_tick();
    wait_cyc(2);
    checks++;
    if (leds !== 8'h55) begin
      errors++;
      $display("FAIL stop_setup leds=%h exp 55", leds);
    end
    d0 = done_cnt;
    tick = 1'b1; stop = 1'b1;
    cyc();
    tick = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || leds !== 8'h00 || step_addr !== 4'd0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL stop_show busy=%b leds=%h addr=%0d done=%b st=%0d exp 0/00/0/0/0", busy, leds, step_addr, done, dbg_state);
    end
    wait_cyc(2);
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL stop_nodone pulses=%0d exp 0", done_cnt - d0);
    end
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_start_idle busy=%b exp 0", busy);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] pat;
    for (int i = 0; i < 16; i++) begin
      pat = 8'(i * 16 + 1);
      write_entry(4'(i), {1'b0, 4'd0, pat});
    end
    pulse_start();
    wait_cyc(2);
    for (int i = 0; i < 18; i++) begin
      pat = 8'((i % 16) * 16 + 1);
      checks++;
      if (leds !== pat || step_addr !== 4'(i % 16) || busy !== 1'b1) begin
        errors++;
        $display("FAIL wrap step=%0d leds=%h addr=%0d busy=%b exp %h/%0d/1", i, leds, step_addr, busy, pat, i % 16);
      end
      pulse_tick();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL wrap_busy step=%0d busy=%b done=%b exp 1/0", i, busy, done);
      end
      wait_cyc(2);
    end
    do_stop();
  endtask

  task automatic test_live_write();
    write_entry(4'd0, {1'b0, 4'd1, 8'hAA});
    write_entry(4'd1, {1'b1, 4'd0, 8'h55});
    loop_en = 1'b1;
    pulse_start();
    wait_cyc(2);
    write_entry(4'd1, {1'b1, 4'd0, 8'h0F});
    pulse_tick(); pulse_tick();
    wait_cyc(2);
    checks++;
    if (leds !== 8'h0F) begin
      errors++;
      $display("FAIL live_ahead leds=%h exp 0F", leds);
    end
    pulse_tick();
    // Now in FETCH of entry 0: write it on the very edge that reads it.
    write_entry(4'd0, {1'b0, 4'd0, 8'hC3});
    cyc();
    checks++;
    if (leds !== 8'hAA) begin
      errors++;
      $display("FAIL live_rbw leds=%h exp AA", leds);
    end
    pulse_tick(); pulse_tick();
    wait_cyc(2);
    pulse_tick();
    wait_cyc(2);
    checks++;
    if (leds !== 8'hC3) begin
      errors++;
      $display("FAIL live_new leds=%h exp C3", leds);
    end
    do_stop();
    loop_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    write_entry(4'd0, {1'b0, 4'd1, 8'hAA});
    write_entry(4'd1, {1'b1, 4'd0, 8'h55});
    pulse_start();
    wait_cyc(2);
    tick = 1'b1; start = 1'b1;
    cyc();
    checks++;
    if (leds !== 8'hAA || dbg_state !== 2'd3 || step_addr !== 4'd0) begin
      errors++;
      $display("FAIL b2b_e1 leds=%h st=%0d addr=%0d exp AA/3/0", leds, dbg_state, step_addr);
    end
    cyc();
    checks++;
    if (dbg_state !== 2'd1 || step_addr !== 4'd1 || leds !== 8'hAA) begin
      errors++;
      $display("FAIL b2b_e2 st=%0d addr=%0d leds=%h exp 1/1/AA", dbg_state, step_addr, leds);
    end
    cyc();
    checks++;
    if (dbg_state !== 2'd2 || step_addr !== 4'd1) begin
      errors++;
      $display("FAIL b2b_e3 st=%0d addr=%0d exp 2/1", dbg_state, step_addr);
    end
    cyc();
    start = 1'b0;
    checks++;
    if (dbg_state !== 2'd3 || leds !== 8'h55 || step_addr !== 4'd1) begin
      errors++;
      $display("FAIL b2b_e4 st=%0d leds=%h addr=%0d exp 3/55/1", dbg_state, leds, step_addr);
    end
    cyc();
    tick = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || leds !== 8'h00) begin
      errors++;
      $display("FAIL b2b_e5 done=%b busy=%b leds=%h exp 1/0/00", done, busy, leds);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_reset_midrun();
    pulse_start();
    wait_cyc(2);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = {1'b1, 4'd0, 8'h3C};
    cyc();
    rst = 1'b0; wr_en = 1'b0;
    checks++;
    if (leds !== 8'h00 || busy !== 1'b0 || step_addr !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid leds=%h busy=%b addr=%0d done=%b exp 00/0/0/0", leds, busy, step_addr, done);
    end
    pulse_start();
    wait_cyc(2);
    checks++;
    if (leds !== 8'h3C) begin
      errors++;
      $display("FAIL rst_write leds=%h exp 3C", leds);
    end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_loop();
    test_stop();
    test_wrap();
    test_live_write();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
